// File: rtl/dual_src_rr_select_pkg.sv
// Shared constants and types for the dual-source round-robin word select.
package dual_src_rr_select_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 2;
   localparam int CNT_W_DEF = 16;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

   // One buffered word with the tag of the source it came from.
   typedef struct packed {
      logic                 src;
      logic [WIDTH_DEF-1:0] data;
   } entry_t;

endpackage

// File: rtl/word_fifo.sv
// Small DEPTH x W circular buffer with push/pop handshake and full/empty flags.
// The head reads as zero while empty so downstream never sees stale words.
module word_fifo
   import dual_src_rr_select_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = WIDTH_DEF + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             count;
   logic                    do_push, do_pop;

   // Flags, guarded handshakes and masked head word.
   always_comb begin
      full    = (count == DEPTH_C);
      empty   = (count == '0);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      head    = empty ? '0 : mem[rd_ptr];
   end

   // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dual_src_rr_select.sv
// Round-robin arbiter over two valid/ready word producers. Drives the word
// select, buffers the chosen word with its source tag, and counts grants.
module dual_src_rr_select
   import dual_src_rr_select_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic [CNT_W-1:0] gnt0_cnt,
   output logic [CNT_W-1:0] gnt1_cnt
);

   logic             last_grant;
   logic             space, gnt_vld, gnt_src, accept, pop;
   logic             fifo_full, fifo_empty;
   logic [WIDTH:0]   push_word, head_word;

   // Grant selection. Space depends only on occupancy, never on out_ready,
   // so there is no combinational path from consumer to producers. Holding
   // rst_n low forces every ready low at once.
   always_comb begin
      space     = rst_n & ~fifo_full;
      gnt_src   = (in0_valid & in1_valid) ? ~last_grant
                                          : (in1_valid ? SRC1 : SRC0);
      gnt_vld   = space & (in0_valid | in1_valid);
      sel       = gnt_vld & gnt_src;
      in0_ready = gnt_vld & ~gnt_src;
      in1_ready = gnt_vld &  gnt_src;
      accept    = gnt_vld;
      push_word = {sel, (sel ? in1_data : in0_data)};
      pop       = ~fifo_empty & out_ready;
      out_valid = ~fifo_empty;
      {out_src, out_data} = head_word;
   end

   word_fifo #(
      .DEPTH (DEPTH),
      .W     (WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_data (push_word),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head_word)
   );

   // Priority rotates only on an actual accept; resets to favour source 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= SRC1;
      else if (accept)
         last_grant <= sel;
   end

   // Per-source grant counters, sticky at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0_cnt <= '0;
         gnt1_cnt <= '0;
      end else if (accept) begin
         if (sel == SRC0 && gnt0_cnt != '1)
            gnt0_cnt <= gnt0_cnt + 1'b1;
         if (sel == SRC1 && gnt1_cnt != '1)
            gnt1_cnt <= gnt1_cnt + 1'b1;
      end
   end

endmodule

// File: doc/dual_src_rr_select.md
Name: dual_src_rr_select

Overview:
- Sits in front of the 32-bit 2:1 word-select datapath and feeds it.
- Arbitrates between two 32-bit valid/ready producers round-robin, then drives the word-select `sel`.
- Captures the selected word with a source tag into a 2-entry output buffer with a valid/ready consumer interface.
- Keeps a saturating grant count per source for status.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, output buffer entries; power of two, at least 2.
- CNT_W, 16, width of the per-source grant counters.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, releases synchronously to clk.
- in0_valid  in  1  source 0 word valid.
- in0_data  in  WIDTH  source 0 word.
- in0_ready  out  1  source 0 word accepted this cycle.
- in1_valid  in  1  source 1 word valid.
- in1_data  in  WIDTH  source 1 word.
- in1_ready  out  1  source 1 word accepted this cycle.
- sel  out  1  current-cycle grant to the word-select datapath; 0 = source 0, 1 = source 1.
- out_valid  out  1  buffer head valid.
- out_data  out  WIDTH  buffer head word.
- out_src  out  1  source tag of the head word.
- out_ready  in  1  consumer takes the head word.
- gnt0_cnt  out  CNT_W  saturating count of accepted source 0 words.
- gnt1_cnt  out  CNT_W  saturating count of accepted source 1 words.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - in0_ready=0, in1_ready=0, sel=0.
  - gnt0_cnt=0, gnt1_cnt=0.
  - buffer count=0, read and write pointers=0.
  - last_grant=1, so source 0 wins the first tie.
- space = (count < DEPTH). A full buffer blocks acceptance even if out_ready=1 in the same cycle. This is deliberate: there is no combinational path from out_ready to inX_ready.
- Grant (combinational, evaluated each cycle when space=1):
  - Only in0_valid: grant 0.
  - Only in1_valid: grant 1.
  - Both valid: grant = ~last_grant.
  - Neither valid, or space=0: no grant; sel holds 0.
- inX_ready = space & grant==X. At most one ready is high in any cycle.
- sel = grant bit. Datapath word = sel ? in1_data : in0_data.
- Accept (inX_valid & inX_ready) at edge N:
  - Write {sel, word} at wr_ptr; wr_ptr++ (wraps modulo DEPTH).
  - last_grant <= sel.
  - Increment the matching gnt counter; it saturates at all-ones.
- Pop (out_valid & out_ready) at edge N: rd_ptr++ (wraps modulo DEPTH).
- Count: +1 on accept only, -1 on pop only, unchanged on simultaneous accept and pop.
- out_valid = count!=0. out_data and out_src show the entry at rd_ptr and are 0 when empty.
- Latency: a word accepted at edge N into an empty buffer is visible at out_* after edge N, i.e. usable in cycle N+1. There is no bypass path.
- Ordering: FIFO order is preserved across sources. A producer may drop valid without a handshake; this has no effect on state.
- last_grant changes only on accept. Idle cycles do not rotate priority.
- Mid-operation reset: all buffered words are discarded at once and every output returns to its reset value within the same cycle. The counters clear.

Decomposition:
- Shared package holds:
  - default WIDTH, DEPTH and CNT_W constants;
  - SRC0=1'b0 and SRC1=1'b1 tag constants;
  - the entry record {src, data} type.
- One sub-module, word_fifo: parameterised DEPTH x (WIDTH+1) storage, pointers and count, with push/pop/full/empty. Arbitration, the select mux and the counters stay in the top level.

Test Plan:
- Reset: hold rst_n=0 with both sources valid -> all readies 0, out_valid=0, counters 0. After release, the first tie grants source 0 (sel=0).
- Tie rotation with out_ready=1 held, in0_data=32'hAAAAAAAA, in1_data=32'h55555555, both valid for 4 cycles:
  - out_data sequence AAAAAAAA, 55555555, AAAAAAAA, 55555555;
  - out_src sequence 0,1,0,1;
  - gnt0_cnt=2, gnt1_cnt=2.
- Single source: only in1_valid, out_ready=1 -> in1_ready=1 every cycle, sel=1, first out_valid one cycle after the first accept.
- Full back-pressure: out_ready=0 with both sources valid:
  - two words are accepted, then in0_ready=in1_ready=0 and sel=0;
  - raising out_ready for one cycle pops one word, and acceptance resumes the following cycle.
- Simultaneous push and pop with count=1 -> count stays 1 and order is preserved across 8 cycles of random data (scoreboard check).
- Asynchronous reset pulse mid-cycle with a full buffer -> out_valid drops before the next clk edge, and buffered data is never delivered.
- Saturation: drive CNT_W=4 with source 0 only for 20 accepts -> gnt0_cnt stays at 4'hF.
